// File: rtl/aes_gcm_pkg.sv
// Shared constants and types for the AES-GCM ingress pipeline.
// Field offsets give the {aad_bits, text_bits} layout of the instance size word.
package aes_gcm_pkg;

    localparam int BLOCK_W    = 128;
    localparam int MAX_BLOCKS = 100000;
    localparam int CNT_W      = 17;

    localparam int AAD_MSB  = 127;
    localparam int AAD_LSB  = 64;
    localparam int TEXT_MSB = 63;
    localparam int TEXT_LSB = 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_TAIL
    } stage0_state_t;

endpackage

// File: rtl/aes_stage0_lane_route.sv
// Per-lane router: steers one block to the AAD path, the plaintext path, or
// neither, depending on where its block index falls within the instance.
module aes_stage0_lane_route
    import aes_gcm_pkg::*;
(
    input  logic [CNT_W-1:0]   idx,
    input  logic [CNT_W-1:0]   aad_blocks,
    input  logic [CNT_W-1:0]   total_blocks,
    input  logic [BLOCK_W-1:0] blk,
    output logic [BLOCK_W-1:0] aad,
    output logic [BLOCK_W-1:0] plain
);

    always_comb begin
        aad   = '0;
        plain = '0;
        if (idx < aad_blocks) begin
            aad = blk;
        end else if (idx < total_blocks) begin
            plain = blk;
        end
    end

endmodule

// File: rtl/aes_pipeline_stage0.sv
// Ingress dispatcher ahead of aes_pipeline_stage1: takes a header beat plus
// two-block data beats and emits one gapless, lane-routed block pair per cycle.
module aes_pipeline_stage0
    import aes_gcm_pkg::*;
#(
    parameter int N_LANES    = 2,
    parameter int MAX_BLOCKS = aes_gcm_pkg::MAX_BLOCKS
)(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic           i_sof,
    input  logic [127:0]   i_cipher_key,
    input  logic [95:0]    i_iv,
    input  logic [63:0]    i_aad_bits,
    input  logic [63:0]    i_text_bits,
    input  logic           i_last,
    input  logic [255:0]   i_blk,
    output logic [127:0]   o_cipher_key,
    output logic [95:0]    o_iv,
    output logic [127:0]   o_instance_size,
    output logic           o_new_instance,
    output logic           o_last_instance,
    output logic [255:0]   o_plain_text,
    output logic [255:0]   o_aad,
    output logic [7:0]     o_id,
    output logic           o_proto_err,
    output logic           o_gap_err
);

    localparam logic [7:0] LANE_IDS = 8'h10;

    stage0_state_t       state;
    logic [CNT_W-1:0]    pair_idx;
    logic [CNT_W-1:0]    last_pair;
    logic [CNT_W-1:0]    aad_blocks;
    logic [CNT_W-1:0]    total_blocks;

    logic                accept;
    logic [57:0]         hdr_total;
    logic [CNT_W-1:0]    hdr_blocks;
    logic [CNT_W-1:0]    hdr_last_pair;
    logic                hdr_oversize;
    logic                hdr_misaligned;
    logic [2*BLOCK_W-1:0] beat;
    logic [2*BLOCK_W-1:0] route_aad;
    logic [2*BLOCK_W-1:0] route_plain;

    assign accept         = i_valid & o_ready;
    assign hdr_total      = 58'(({1'b0, i_aad_bits} + {1'b0, i_text_bits}) >> 7);
    assign hdr_oversize   = hdr_total > 58'(MAX_BLOCKS);
    assign hdr_blocks     = hdr_total[CNT_W-1:0];
    assign hdr_last_pair  = (hdr_blocks - 1'b1) >> 1;
    assign hdr_misaligned = (|i_aad_bits[6:0]) | (|i_text_bits[6:0]);

    // A STREAM cycle without a beat still emits a pair, built from zero data.
    assign beat = (state == S_STREAM && accept) ? i_blk : '0;

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        logic [CNT_W-1:0] idx;
        assign idx = CNT_W'({pair_idx, 1'b0} + CNT_W'(g));

        aes_stage0_lane_route u_route (
            .idx          (idx),
            .aad_blocks   (aad_blocks),
            .total_blocks (total_blocks),
            .blk          (beat[g*BLOCK_W +: BLOCK_W]),
            .aad          (route_aad[g*BLOCK_W +: BLOCK_W]),
            .plain        (route_plain[g*BLOCK_W +: BLOCK_W])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            pair_idx        <= '0;
            last_pair       <= '0;
            aad_blocks      <= '0;
            total_blocks    <= '0;
            o_ready         <= 1'b0;
            o_cipher_key    <= '0;
            o_iv            <= '0;
            o_instance_size <= '0;
            o_new_instance  <= 1'b0;
            o_last_instance <= 1'b0;
            o_plain_text    <= '0;
            o_aad           <= '0;
            o_id            <= '0;
            o_proto_err     <= 1'b0;
            o_gap_err       <= 1'b0;
        end else begin
            o_ready        <= 1'b1;
            o_new_instance <= 1'b0;
            o_proto_err    <= 1'b0;
            o_plain_text   <= '0;
            o_aad          <= '0;
            o_id           <= '0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (!i_sof || hdr_oversize) begin
                            o_proto_err <= 1'b1;
                        end else begin
                            o_cipher_key                       <= i_cipher_key;
                            o_iv                               <= i_iv;
                            o_instance_size[AAD_MSB:AAD_LSB]   <= i_aad_bits;
                            o_instance_size[TEXT_MSB:TEXT_LSB] <= i_text_bits;
                            o_last_instance                    <= i_last;
                            o_gap_err                          <= 1'b0;
                            o_proto_err                        <= hdr_misaligned;
                            aad_blocks                         <= i_aad_bits[CNT_W+6:7];
                            total_blocks                       <= hdr_blocks;
                            last_pair                          <= hdr_last_pair;
                            pair_idx                           <= '0;
                            if (hdr_blocks != '0) begin
                                state <= S_STREAM;
                            end
                        end
                    end
                end
                S_STREAM: begin
                    o_plain_text   <= route_plain;
                    o_aad          <= route_aad;
                    o_id           <= LANE_IDS;
                    o_new_instance <= (pair_idx == '0);
                    if (!accept) begin
                        o_gap_err <= 1'b1;
                    end
                    if (accept && i_sof) begin
                        o_proto_err <= 1'b1;
                    end
                    // The TAIL cycle refuses input so stage1 sees a clean gap between instances.
                    if (pair_idx == last_pair) begin
                        state   <= S_TAIL;
                        o_ready <= 1'b0;
                    end else begin
                        pair_idx <= pair_idx + 1'b1;
                    end
                end
                S_TAIL: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_pipeline_stage0.sv
// Table-driven bench for aes_pipeline_stage0: scenarios expand into per-cycle
// stimulus and expected outputs derived from block-index and timing rules.
module tb_aes_pipeline_stage0;

    localparam int TBL_N  = 1024;
    localparam longint MAX_B = 100000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_valid = 1'b0;
    logic         i_sof = 1'b0;
    logic [127:0] i_cipher_key = '0;
    logic [95:0]  i_iv = '0;
    logic [63:0]  i_aad_bits = '0;
    logic [63:0]  i_text_bits = '0;
    logic         i_last = 1'b0;
    logic [255:0] i_blk = '0;
    logic         o_ready;
    logic [127:0] o_cipher_key;
    logic [95:0]  o_iv;
    logic [127:0] o_instance_size;
    logic         o_new_instance;
    logic         o_last_instance;
    logic [255:0] o_plain_text;
    logic [255:0] o_aad;
    logic [7:0]   o_id;
    logic         o_proto_err;
    logic         o_gap_err;

    always #5 clk = ~clk;

    aes_pipeline_stage0 dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_valid         (i_valid),
        .o_ready         (o_ready),
        .i_sof           (i_sof),
        .i_cipher_key    (i_cipher_key),
        .i_iv            (i_iv),
        .i_aad_bits      (i_aad_bits),
        .i_text_bits     (i_text_bits),
        .i_last          (i_last),
        .i_blk           (i_blk),
        .o_cipher_key    (o_cipher_key),
        .o_iv            (o_iv),
        .o_instance_size (o_instance_size),
        .o_new_instance  (o_new_instance),
        .o_last_instance (o_last_instance),
        .o_plain_text    (o_plain_text),
        .o_aad           (o_aad),
        .o_id            (o_id),
        .o_proto_err     (o_proto_err),
        .o_gap_err       (o_gap_err)
    );

    typedef struct {
        bit           rst;
        bit           valid;
        bit           sof;
        logic [127:0] key;
        logic [95:0]  iv;
        logic [63:0]  aad;
        logic [63:0]  text;
        bit           last;
        logic [255:0] blk;
        bit           e_rst;
        bit           e_ready;
        logic [255:0] e_plain;
        logic [255:0] e_aad;
        logic [7:0]   e_id;
        bit           e_new;
        bit           e_proto;
        bit           ev_hdr;
        bit           ev_gap;
        logic [127:0] e_key;
        logic [95:0]  e_iv;
        logic [127:0] e_size;
        bit           e_last;
        bit           e_gap;
    } vec_t;

    vec_t tbl[TBL_N];
    int   wr;
    int   checks;
    int   errors;

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic cmp(input string name, input int cyc, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    // Reset held for n cycles starting at wr; outputs read as reset from the next sample on.
    task automatic add_reset(input int n);
        int k;
        k = wr;
        for (int j = 0; j < n; j++) tbl[k+j].rst = 1'b1;
        for (int j = 1; j <= n; j++) begin
            tbl[k+j].e_rst   = 1'b1;
            tbl[k+j].e_ready = 1'b0;
        end
        wr = k + n + 1;
    endtask

    task automatic add_stray();
        tbl[wr].valid     = 1'b1;
        tbl[wr].sof       = 1'b0;
        tbl[wr].blk       = {rand128(), rand128()};
        tbl[wr+1].e_proto = 1'b1;
        wr++;
    endtask

    task automatic add_instance(input logic [63:0] aad_bits, input logic [63:0] text_bits,
                                input logic [31:0] gap_mask, input int sof_p, input int abort_p);
        logic [64:0]  total_bits;
        logic [127:0] b;
        longint       aad_b, total_b, pairs, k;
        int           t, c;
        t = wr;
        tbl[t].valid = 1'b1;
        tbl[t].sof   = 1'b1;
        tbl[t].key   = rand128();
        tbl[t].iv    = 96'(rand128());
        tbl[t].aad   = aad_bits;
        tbl[t].text  = text_bits;
        tbl[t].last  = 1'($urandom_range(0, 1));
        total_bits = {1'b0, aad_bits} + {1'b0, text_bits};
        total_b    = longint'(total_bits / 128);
        aad_b      = longint'(aad_bits / 128);
        tbl[t+1].e_proto = (aad_bits % 128 != 0) || (text_bits % 128 != 0) || (total_b > MAX_B);
        if (total_b > MAX_B) begin
            wr = t + 1;
            return;
        end
        tbl[t].ev_hdr = 1'b1;
        if (total_b == 0) begin
            wr = t + 1;
            return;
        end
        pairs = (total_b + 1) / 2;
        for (int p = 0; p < pairs; p++) begin
            c = t + 1 + p;
            if (p == abort_p) begin
                wr = c;
                add_reset(2);
                return;
            end
            if (gap_mask[p]) begin
                tbl[c].ev_gap = 1'b1;
            end else begin
                tbl[c].valid = 1'b1;
                tbl[c].blk   = {rand128(), rand128()};
                if (p == sof_p) begin
                    tbl[c].sof  = 1'b1;
                    tbl[c].key  = rand128();
                    tbl[c].aad  = 64'(rand128());
                    tbl[c].text = 64'(rand128());
                    tbl[c+1].e_proto = 1'b1;
                end
            end
            tbl[c+1].e_id  = 8'h10;
            tbl[c+1].e_new = (p == 0);
            for (int l = 0; l < 2; l++) begin
                k = 2 * p + l;
                b = gap_mask[p] ? 128'd0 : tbl[c].blk[l*128 +: 128];
                if (k < aad_b) tbl[c+1].e_aad[l*128 +: 128] = b;
                else if (k < total_b) tbl[c+1].e_plain[l*128 +: 128] = b;
            end
        end
        c = t + 1 + int'(pairs);
        tbl[c].e_ready = 1'b0;
        tbl[c].valid   = 1'b1;
        tbl[c].sof     = 1'b1;
        tbl[c].aad     = 64'(rand128());
        tbl[c].text    = 64'(rand128());
        wr = c + 1;
    endtask

    task automatic compute_held();
        logic [127:0] key;
        logic [95:0]  iv;
        logic [127:0] size;
        bit           last;
        bit           gap;
        key = '0; iv = '0; size = '0; last = 1'b0; gap = 1'b0;
        for (int i = 0; i < TBL_N; i++) begin
            if (tbl[i].e_rst) begin
                key = '0; iv = '0; size = '0; last = 1'b0; gap = 1'b0;
            end
            tbl[i].e_key  = key;
            tbl[i].e_iv   = iv;
            tbl[i].e_size = size;
            tbl[i].e_last = last;
            tbl[i].e_gap  = gap;
            if (tbl[i].ev_hdr) begin
                key  = tbl[i].key;
                iv   = tbl[i].iv;
                size = {tbl[i].aad, tbl[i].text};
                last = tbl[i].last;
                gap  = 1'b0;
            end
            if (tbl[i].ev_gap) gap = 1'b1;
        end
    endtask

    task automatic checkOutput(input int i);
        cmp("ready",         i, 256'(o_ready),         256'(tbl[i].e_ready));
        cmp("plain_text",    i, o_plain_text,          tbl[i].e_plain);
        cmp("aad",           i, o_aad,                 tbl[i].e_aad);
        cmp("id",            i, 256'(o_id),            256'(tbl[i].e_id));
        cmp("new_instance",  i, 256'(o_new_instance),  256'(tbl[i].e_new));
        cmp("proto_err",     i, 256'(o_proto_err),     256'(tbl[i].e_proto));
        cmp("gap_err",       i, 256'(o_gap_err),       256'(tbl[i].e_gap));
        cmp("cipher_key",    i, 256'(o_cipher_key),    256'(tbl[i].e_key));
        cmp("iv",            i, 256'(o_iv),            256'(tbl[i].e_iv));
        cmp("instance_size", i, 256'(o_instance_size), 256'(tbl[i].e_size));
        cmp("last_instance", i, 256'(o_last_instance), 256'(tbl[i].e_last));
    endtask

    task automatic applyStimulus(input int i);
        if (tbl[i].rst && rst_n) begin
            rst_n = 1'b0;
            #1;
            cmp("async_reset", i,
                256'({o_ready, o_new_instance, o_proto_err, o_gap_err, o_id, o_cipher_key}) | o_plain_text | o_aad,
                256'd0);
        end else begin
            rst_n = !tbl[i].rst;
        end
        i_valid      = tbl[i].valid;
        i_sof        = tbl[i].sof;
        i_cipher_key = tbl[i].key;
        i_iv         = tbl[i].iv;
        i_aad_bits   = tbl[i].aad;
        i_text_bits  = tbl[i].text;
        i_last       = tbl[i].last;
        i_blk        = tbl[i].blk;
    endtask

    initial begin
        int aad_blk, txt_blk;
        logic [63:0] aad_bits, text_bits;
        checks = 0;
        errors = 0;
        for (int i = 0; i < TBL_N; i++) begin
            tbl[i] = '{default: 0};
            tbl[i].e_ready = 1'b1;
        end

        wr = 0;
        tbl[0].e_rst   = 1'b1;
        tbl[0].e_ready = 1'b0;
        add_reset(3);
        add_stray();
        add_instance(64'd256, 64'd384, 32'd0, -1, -1);
        add_instance(64'd128, 64'd256, 32'd0, -1, -1);
        add_instance(64'd0, 64'd0, 32'd0, -1, -1);
        add_instance(64'd0, 64'((MAX_B + 1) * 128), 32'd0, -1, -1);
        add_instance(64'd128, 64'd640, 32'b10, -1, -1);
        add_instance(64'd256, 64'd512, 32'd0, 1, -1);
        add_stray();
        add_instance(64'd100, 64'd300, 32'd0, -1, -1);
        add_instance(64'd0, 64'd128, 32'd0, -1, -1);
        wr += 2;
        add_instance(64'd256, 64'd1024, 32'd0, -1, 2);
        add_instance(64'd128, 64'd384, 32'd0, -1, -1);

        for (int n = 0; n < 30; n++) begin
            if (wr > TBL_N - 40) break;
            aad_blk   = $urandom_range(0, 5);
            txt_blk   = $urandom_range(0, 7);
            aad_bits  = 64'(aad_blk * 128);
            text_bits = 64'(txt_blk * 128);
            if ($urandom_range(0, 7) == 0) aad_bits  += 64'($urandom_range(1, 127));
            if ($urandom_range(0, 7) == 0) text_bits += 64'($urandom_range(1, 127));
            add_instance(aad_bits, text_bits, $urandom & $urandom & $urandom,
                         ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1, -1);
            if ($urandom_range(0, 5) == 0) add_stray();
            wr += $urandom_range(0, 2);
        end

        compute_held();

        $display("[TB] running %0d table cycles", wr + 3);
        for (int i = 0; i < wr + 3; i++) begin
            @(negedge clk);
            checkOutput(i);
            applyStimulus(i);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
